// File: rtl/spi_xfer_sequencer.sv
// SPI transfer sequencer: turns one command into the register-file bus sequence for a
// complete SPI transfer (divider, slave select, data, go, poll, readback) and returns the result.
module spi_xfer_sequencer #(
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned POLL_LIMIT = 1024,
  parameter int unsigned POLL_GAP   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [REG_WIDTH-1:0] cmd_tx_data,
  input  logic [6:0]           cmd_char_len,
  input  logic [7:0]           cmd_ss,
  input  logic [15:0]          cmd_divider,
  input  logic [4:0]           cmd_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [REG_WIDTH-1:0] rsp_rx_data,
  output logic [1:0]           rsp_err,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [ADDR_SIZE-1:0] bus_addr,
  output logic [REG_WIDTH-1:0] bus_wdata,
  input  logic                 bus_ack,
  input  logic [REG_WIDTH-1:0] bus_rdata,
  output logic                 busy
);

  localparam logic [ADDR_SIZE-1:0] AddrRxtx = ADDR_SIZE'(8'h00);
  localparam logic [ADDR_SIZE-1:0] AddrCtrl = ADDR_SIZE'(8'h10);
  localparam logic [ADDR_SIZE-1:0] AddrDiv  = ADDR_SIZE'(8'h14);
  localparam logic [ADDR_SIZE-1:0] AddrSs   = ADDR_SIZE'(8'h18);
  localparam int unsigned GapLastInt = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;
  localparam logic [3:0]  GapLast    = 4'(GapLastInt);
  localparam logic [15:0] PollLimit  = 16'(POLL_LIMIT);

  typedef enum logic [3:0] {
    StIdle, StCheck, StWrDiv, StWrSs, StWrTx, StWrCtrl, StPoll, StGap, StRdRx, StClrSs, StResp
  } state_e;

  state_e                 state_q, state_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [REG_WIDTH-1:0]   rsp_rx_q, rsp_rx_d;
  logic [1:0]             rsp_err_q, rsp_err_d;
  logic                   bus_req_q, bus_req_d;
  logic                   bus_we_q, bus_we_d;
  logic [ADDR_SIZE-1:0]   bus_addr_q, bus_addr_d;
  logic [REG_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
  logic                   busy_q, busy_d;
  logic [REG_WIDTH-1:0]   tx_q, tx_d;
  logic [6:0]             len_q, len_d;
  logic [7:0]             ss_q, ss_d;
  logic [15:0]            div_q, div_d;
  logic [4:0]             flags_q, flags_d;
  logic [15:0]            div_cache_q, div_cache_d;
  logic                   div_valid_q, div_valid_d;
  logic [15:0]            poll_cnt_q, poll_cnt_d;
  logic [3:0]             gap_cnt_q, gap_cnt_d;

  logic                   ack;
  logic [15:0]            poll_inc;
  logic                   issue, issue_we;
  logic [ADDR_SIZE-1:0]   issue_addr;
  logic [REG_WIDTH-1:0]   issue_wdata;

  // Acks are only meaningful against our own outstanding request.
  assign ack      = bus_req_q & bus_ack;
  assign poll_inc = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rx_d    = rsp_rx_q;
    rsp_err_d   = rsp_err_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    tx_d        = tx_q;
    len_d       = len_q;
    ss_d        = ss_q;
    div_d       = div_q;
    flags_d     = flags_q;
    div_cache_d = div_cache_q;
    div_valid_d = div_valid_q;
    poll_cnt_d  = poll_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    issue       = 1'b0;
    issue_we    = 1'b0;
    issue_addr  = '0;
    issue_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          tx_d        = cmd_tx_data;
          len_d       = cmd_char_len;
          ss_d        = cmd_ss;
          div_d       = cmd_divider;
          flags_d     = cmd_flags;
          cmd_ready_d = 1'b0;
          state_d     = StCheck;
        end
      end
      StCheck: begin
        if (len_q == 7'd0 || len_q > 7'd32) begin
          rsp_err_d   = 2'b10;
          rsp_rx_d    = '0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (!div_valid_q || div_q != div_cache_q) begin
          state_d = StWrDiv;
        end else begin
          state_d = StWrSs;
        end
      end
      StWrDiv: begin
        issue       = 1'b1;
        issue_we    = 1'b1;
        issue_addr  = AddrDiv;
        issue_wdata = REG_WIDTH'(div_q);
        if (ack) begin
          div_cache_d = div_q;
          div_valid_d = 1'b1;
          state_d     = StWrSs;
        end
      end
      StWrSs: begin
        issue       = 1'b1;
        issue_we    = 1'b1;
        issue_addr  = AddrSs;
        issue_wdata = REG_WIDTH'(ss_q);
        if (ack) state_d = StWrTx;
      end
      StWrTx: begin
        issue       = 1'b1;
        issue_we    = 1'b1;
        issue_addr  = AddrRxtx;
        issue_wdata = tx_q;
        if (ack) state_d = StWrCtrl;
      end
      StWrCtrl: begin
        issue       = 1'b1;
        issue_we    = 1'b1;
        issue_addr  = AddrCtrl;
        issue_wdata = REG_WIDTH'({18'b0, flags_q, 1'b1, 1'b0, len_q});
        if (ack) begin
          poll_cnt_d = '0;
          state_d    = StPoll;
        end
      end
      StPoll: begin
        issue      = 1'b1;
        issue_addr = AddrCtrl;
        if (ack) begin
          poll_cnt_d = poll_inc;
          if (!bus_rdata[8]) begin
            state_d = StRdRx;
          end else if (poll_inc == PollLimit) begin
            state_d = StClrSs;
          end else if (POLL_GAP != 0) begin
            gap_cnt_d = '0;
            state_d   = StGap;
          end
        end
      end
      StGap: begin
        // The next poll is launched from here so the bus sees exactly POLL_GAP idle cycles.
        if (gap_cnt_q == GapLast) begin
          issue      = 1'b1;
          issue_addr = AddrCtrl;
          state_d    = StPoll;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      StRdRx: begin
        issue      = 1'b1;
        issue_addr = AddrRxtx;
        if (ack) begin
          rsp_rx_d    = bus_rdata;
          rsp_err_d   = 2'b00;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StClrSs: begin
        issue      = 1'b1;
        issue_we   = 1'b1;
        issue_addr = AddrSs;
        if (ack) begin
          div_valid_d = 1'b0;
          rsp_rx_d    = '0;
          rsp_err_d   = 2'b01;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus_req_q) begin
      if (bus_ack) bus_req_d = 1'b0;
    end else if (issue) begin
      bus_req_d   = 1'b1;
      bus_we_d    = issue_we;
      bus_addr_d  = issue_addr;
      bus_wdata_d = issue_wdata;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rx_q    <= '0;
      rsp_err_q   <= 2'b00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      busy_q      <= 1'b0;
      tx_q        <= '0;
      len_q       <= '0;
      ss_q        <= '0;
      div_q       <= '0;
      flags_q     <= '0;
      div_cache_q <= '0;
      div_valid_q <= 1'b0;
      poll_cnt_q  <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rx_q    <= rsp_rx_d;
      rsp_err_q   <= rsp_err_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      busy_q      <= busy_d;
      tx_q        <= tx_d;
      len_q       <= len_d;
      ss_q        <= ss_d;
      div_q       <= div_d;
      flags_q     <= flags_d;
      div_cache_q <= div_cache_d;
      div_valid_q <= div_valid_d;
      poll_cnt_q  <= poll_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rx_data = rsp_rx_q;
  assign rsp_err     = rsp_err_q;
  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign busy        = busy_q;

endmodule
